regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- Parametrised successor to the fixed 4-to-16 register write decoder.
- Generalises to 2**ADDR_W registers and adds a pipelined one-hot write-enable path gated by wb_valid.
- Keeps a per-register pending-write scoreboard with RAW/WAW hazard stall, same-cycle writeback bypass, occupancy count and a sticky protocol-error flag.
- Sits between the issue stage and the register file.

Parameters:
- ADDR_W, 4: register address width.
- NUM_REGS, 2**ADDR_W: register count. Derived; not overridden.
- WE_LAT, 1: cycles from wb_valid to we_onehot. Legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- issue_valid  input  1  instruction presented for issue
- issue_addr  input  ADDR_W  destination register of issuing instruction
- rd_en_a  input  1  source operand A used
- rd_addr_a  input  ADDR_W  source register A
- rd_en_b  input  1  source operand B used
- rd_addr_b  input  ADDR_W  source register B
- wb_valid  input  1  writeback completes this cycle
- wb_addr  input  ADDR_W  writeback destination register
- we_onehot  output  NUM_REGS  delayed one-hot register write enable
- pending  output  NUM_REGS  scoreboard; bit i=1 means write to reg i outstanding
- stall  output  1  combinational; issue blocked this cycle
- issue_accept  output  1  combinational; issue_valid & ~stall
- pend_count  output  ADDR_W+1  registered popcount of pending
- wb_err  output  1  sticky; writeback to a non-pending register seen

Behaviour:
- Reset (reset_n low, async):
  - pending, we_onehot, pend_count, wb_err and all WE_LAT pipeline stages = 0.
  - Reset mid-operation discards in-flight write enables and all pending state.
- Effective pending (combinational):
  - eff[i] = pending[i] & ~(wb_valid & wb_addr==i).
  - A same-cycle writeback bypasses the hazard.
- Stall (combinational, evaluated only when issue_valid=1; 0 otherwise):
  - stall = issue_valid & ( (rd_en_a & eff[rd_addr_a]) | (rd_en_b & eff[rd_addr_b]) | eff[issue_addr] ).
  - The eff[issue_addr] term is the WAW check.
- Scoreboard update at posedge:
  - clear = wb_valid ? onehot(wb_addr) : 0
  - set = issue_accept ? onehot(issue_addr) : 0
  - pending_next = (pending & ~clear) | set
  - Set wins over clear on the same register: issue and writeback to reg k in one cycle leaves pending[k]=1.
- Error flag:
  - wb_err sets when wb_valid & ~pending[wb_addr] at the edge. Cleared only by reset.
  - The scoreboard bit stays 0 on an erroneous writeback; the write enable is still produced.
- pend_count:
  - Equals popcount(pending) as registered, updated on the same edge as pending.
  - Max value NUM_REGS; width ADDR_W+1, so no wrap.
- Write-enable pipeline:
  - Stage0 = wb_valid ? onehot(wb_addr) : 0, registered.
  - we_onehot is the stage WE_LAT-1 output, so wb_valid at edge n appears on we_onehot after edge n+WE_LAT-1, i.e. WE_LAT cycles later.
  - At most one bit set at any time. Back-to-back writebacks are fully pipelined; no bubbles.
- Parameter check: WE_LAT outside 1..4 is an elaboration error.
- Outputs stall and issue_accept have no latency; all other outputs are registered.

Test Plan:
- Reset: hold reset_n=0 mid-stream with pending=16'h00F0 → pending=0, we_onehot=0, pend_count=0, wb_err=0 immediately (async).
- Decode sweep: WE_LAT=1, wb_valid=1 with wb_addr 0..15 on consecutive cycles → we_onehot one cycle later = 1<<addr; wb_valid=0 → we_onehot=0. Repeat with WE_LAT=3 and check 3-cycle delay.
- RAW stall:
  - Issue dest r5 → pending[5]=1, pend_count=1.
  - Next issue with rd_en_a=1, rd_addr_a=5 → stall=1, issue_accept=0, pending unchanged.
  - wb_valid with wb_addr=5 in the same cycle → stall=0, accepted.
- WAW plus simultaneous set/clear:
  - pending[3]=1; issue dest r3 with wb_addr=3 in the same cycle → issue_accept=1, pending[3] remains 1, pend_count unchanged.
  - Issue dest r3 without wb → stall=1.
- Fill: issue dests 0..15 with no sources → pend_count reaches 16, pending=16'hFFFF; any further issue stalls.
- Protocol error: wb_valid, wb_addr=9 with pending[9]=0 → wb_err=1 next edge and stays 1; pending[9]=0; we_onehot[9] pulses after WE_LAT.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard
//   Pending-write scoreboard and pipelined one-hot write-enable decoder,
//   placed between the issue stage and a 2**ADDR_W entry register file.
//   It blocks issue on RAW/WAW hazards against outstanding writes. A
//   writeback arriving in the same cycle releases the hazard.
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   issue_valid/addr  instruction presented for issue and its destination
//   rd_en_a/rd_addr_a source operand A used / register
//   rd_en_b/rd_addr_b source operand B used / register
//   wb_valid/wb_addr  writeback completing this cycle / destination
//   we_onehot         one-hot register write enable, WE_LAT cycles after wb
//   pending           scoreboard, bit i = write to reg i outstanding
//   stall             combinational, issue blocked this cycle
//   issue_accept      combinational, issue_valid & ~stall
//   pend_count        registered popcount of pending
//   wb_err            sticky, writeback to a non-pending register seen
module regfile_wb_scoreboard #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 2**ADDR_W,
  parameter int unsigned WE_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] we_onehot,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall,
  output logic                issue_accept,
  output logic [ADDR_W:0]     pend_count,
  output logic                wb_err
);

  generate
    if (WE_LAT < 1 || WE_LAT > 4) begin : g_bad_we_lat
      $error("regfile_wb_scoreboard: WE_LAT must be within 1..4");
    end
  endgenerate

  logic [NUM_REGS-1:0] r_pending;
  logic [ADDR_W:0]     r_pend_count;
  logic                r_wb_err;
  logic [NUM_REGS-1:0] r_we_pipe [WE_LAT];

  logic [NUM_REGS-1:0] w_clear;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_pend_next;
  logic [ADDR_W:0]     w_pend_pop;
  logic                w_stall;
  logic                w_accept;

  always_comb begin
    w_clear = '0;
    if (wb_valid) w_clear[wb_addr] = 1'b1;

    // Same-cycle writeback hides its register from the hazard check.
    w_eff = r_pending & ~w_clear;

    // Last term is the WAW check on the destination.
    w_stall = issue_valid & ((rd_en_a & w_eff[rd_addr_a]) |
                             (rd_en_b & w_eff[rd_addr_b]) |
                             w_eff[issue_addr]);
    w_accept = issue_valid & ~w_stall;

    w_set = '0;
    if (w_accept) w_set[issue_addr] = 1'b1;

    // Set applied after clear so a new issue wins over a same-cycle writeback.
    w_pend_next = (r_pending & ~w_clear) | w_set;

    w_pend_pop = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      w_pend_pop = w_pend_pop + {{ADDR_W{1'b0}}, w_pend_next[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_pend_count <= '0;
      r_wb_err     <= 1'b0;
    end else begin
      r_pending    <= w_pend_next;
      r_pend_count <= w_pend_pop;
      if (wb_valid && !r_pending[wb_addr]) r_wb_err <= 1'b1;
    end
  end

  // Stage 0 holds the decoded writeback; later stages are pure delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WE_LAT; i++) r_we_pipe[i] <= '0;
    end else begin
      r_we_pipe[0] <= w_clear;
      for (int unsigned i = 1; i < WE_LAT; i++) r_we_pipe[i] <= r_we_pipe[i-1];
    end
  end

  assign we_onehot    = r_we_pipe[WE_LAT-1];
  assign pending      = r_pending;
  assign pend_count   = r_pend_count;
  assign wb_err       = r_wb_err;
  assign stall        = w_stall;
  assign issue_accept = w_accept;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb_regfile_wb_scoreboard
//   Two instances share all inputs: u_dut1 with WE_LAT=1, u_dut3 with WE_LAT=3.
//   Expected values come from a small model: a pending bit array, a sticky
//   error bit and a history of writebacks from which delayed enables are read.
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid, rd_en_a, rd_en_b, wb_valid;
  logic [3:0]  issue_addr, rd_addr_a, rd_addr_b, wb_addr;

  logic [15:0] we1, pend1, we3, pend3;
  logic        stall1, acc1, err1, stall3, acc3, err3;
  logic [4:0]  cnt1, cnt3;

  int n_total = 0;
  int n_pass  = 0;

  bit [15:0] m_pend;
  bit        m_err;
  bit        hv[$];
  int        ha[$];

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.ADDR_W(4), .WE_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .we_onehot(we1), .pending(pend1), .stall(stall1),
    .issue_accept(acc1), .pend_count(cnt1), .wb_err(err1));

  regfile_wb_scoreboard #(.ADDR_W(4), .WE_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .we_onehot(we3), .pending(pend3), .stall(stall3),
    .issue_accept(acc3), .pend_count(cnt3), .wb_err(err3));

  // A register blocks issue when its write is still outstanding after
  // accounting for the writeback happening right now.
  function automatic bit busy(input int r);
    return m_pend[r] && !(wb_valid && int'(wb_addr) == r);
  endfunction

  function automatic bit m_stall();
    return issue_valid && ((rd_en_a && busy(int'(rd_addr_a))) ||
                           (rd_en_b && busy(int'(rd_addr_b))) ||
                           busy(int'(issue_addr)));
  endfunction

  function automatic logic [4:0] m_count();
    int c = 0;
    for (int r = 0; r < 16; r++) if (m_pend[r]) c++;
    return 5'(c);
  endfunction

  // Write enable visible now for a pipe of depth lat: the writeback
  // sampled lat-1 edges before the most recent one.
  function automatic logic [15:0] m_we(input int lat);
    logic [15:0] v = '0;
    if (hv.size() >= lat && hv[hv.size()-lat]) v[ha[ha.size()-lat]] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    issue_valid = 0; issue_addr = 0; rd_en_a = 0; rd_addr_a = 0;
    rd_en_b = 0; rd_addr_b = 0; wb_valid = 0; wb_addr = 0;
  endtask

  task automatic model_clear();
    m_pend = '0; m_err = 0; hv.delete(); ha.delete();
  endtask

  // Advance one clock edge and apply the scoreboard rules to the model.
  task automatic tick();
    bit acc;
    acc = issue_valid && !m_stall();
    @(posedge clk);
    if (wb_valid) begin
      if (!m_pend[wb_addr]) m_err = 1;
      m_pend[wb_addr] = 0;
    end
    if (acc) m_pend[issue_addr] = 1;
    hv.push_back(wb_valid);
    ha.push_back(int'(wb_addr));
    if (hv.size() > 8) begin
      void'(hv.pop_front());
      void'(ha.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 0;
    model_clear();
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_total++;
    if ({pend1, we1, cnt1, err1, we3} !== '0)
      $display("FAIL reset_state: got p=%h we=%h cnt=%0d err=%b we3=%h required all 0",
               pend1, we1, cnt1, err1, we3);
    else n_pass++;
    model_clear();
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_decode();
    for (int a = 0; a < 16; a++) begin
      wb_valid = 1; wb_addr = 4'(a);
      tick();
      n_total++;
      if (we1 !== m_we(1) || we1 !== (16'h1 << a))
        $display("FAIL decode_lat1[%0d]: got %h required %h", a, we1, 16'h1 << a);
      else n_pass++;
      n_total++;
      if (we3 !== m_we(3))
        $display("FAIL decode_lat3[%0d]: got %h required %h", a, we3, m_we(3));
      else n_pass++;
    end
    wb_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (we1 !== 16'h0 || we3 !== m_we(3))
        $display("FAIL decode_drain[%0d]: got we1=%h we3=%h required 0 / %h",
                 k, we1, we3, m_we(3));
      else n_pass++;
    end
    n_total++;
    if (we3 !== 16'h0) $display("FAIL decode_idle3: got %h required 0", we3);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_raw();
    issue_valid = 1; issue_addr = 5;
    tick();
    n_total++;
    if (pend1 !== 16'h0020 || cnt1 !== 5'd1)
      $display("FAIL raw_issue: got p=%h cnt=%0d required 0020 / 1", pend1, cnt1);
    else n_pass++;
    issue_addr = 7; rd_en_a = 1; rd_addr_a = 5;
    #1;
    n_total++;
    if (stall1 !== 1'b1 || acc1 !== 1'b0)
      $display("FAIL raw_stall: got stall=%b acc=%b required 1 / 0", stall1, acc1);
    else n_pass++;
    tick();
    n_total++;
    if (pend1 !== 16'h0020) $display("FAIL raw_hold: got %h required 0020", pend1);
    else n_pass++;
    wb_valid = 1; wb_addr = 5;
    #1;
    n_total++;
    if (stall1 !== 1'b0 || acc1 !== 1'b1)
      $display("FAIL raw_bypass: got stall=%b acc=%b required 0 / 1", stall1, acc1);
    else n_pass++;
    tick();
    n_total++;
    if (pend1 !== 16'h0080 || cnt1 !== 5'd1 || we1 !== 16'h0020)
      $display("FAIL raw_after: got p=%h cnt=%0d we=%h required 0080 / 1 / 0020",
               pend1, cnt1, we1);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_waw();
    issue_valid = 1; issue_addr = 3;
    tick();
    wb_valid = 1; wb_addr = 3;
    #1;
    n_total++;
    if (acc1 !== 1'b1) $display("FAIL waw_setclr_acc: got %b required 1", acc1);
    else n_pass++;
    tick();
    n_total++;
    if (pend1 !== 16'h0008 || cnt1 !== 5'd1 || err1 !== 1'b0)
      $display("FAIL waw_setclr: got p=%h cnt=%0d err=%b required 0008 / 1 / 0",
               pend1, cnt1, err1);
    else n_pass++;
    wb_valid = 0;
    #1;
    n_total++;
    if (stall1 !== 1'b1 || acc1 !== 1'b0)
      $display("FAIL waw_stall: got stall=%b acc=%b required 1 / 0", stall1, acc1);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_fill();
    issue_valid = 1;
    for (int r = 0; r < 16; r++) begin
      issue_addr = 4'(r);
      #1;
      n_total++;
      if (acc1 !== 1'b1) $display("FAIL fill_acc[%0d]: got %b required 1", r, acc1);
      else n_pass++;
      tick();
    end
    n_total++;
    if (pend1 !== 16'hFFFF || cnt1 !== 5'd16 || cnt1 !== m_count())
      $display("FAIL fill_full: got p=%h cnt=%0d required FFFF / 16", pend1, cnt1);
    else n_pass++;
    issue_addr = 4'($urandom_range(0, 15));
    #1;
    n_total++;
    if (stall1 !== 1'b1) $display("FAIL fill_stall: got %b required 1", stall1);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_wb_err();
    wb_valid = 1; wb_addr = 9;
    tick();
    n_total++;
    if (err1 !== 1'b1 || pend1[9] !== 1'b0 || we1 !== 16'h0200)
      $display("FAIL err_set: got err=%b p9=%b we=%h required 1 / 0 / 0200",
               err1, pend1[9], we1);
    else n_pass++;
    wb_valid = 0;
    tick();
    n_total++;
    if (err1 !== 1'b1 || we1 !== 16'h0 || we3 !== 16'h0)
      $display("FAIL err_sticky: got err=%b we1=%h we3=%h required 1 / 0 / 0",
               err1, we1, we3);
    else n_pass++;
    tick();
    n_total++;
    if (we3 !== 16'h0200 || we3 !== m_we(3) || err1 !== m_err)
      $display("FAIL err_we3: got we3=%h err=%b required 0200 / 1", we3, err1);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_async_reset();
    issue_valid = 1;
    for (int r = 4; r < 8; r++) begin
      issue_addr = 4'(r);
      if (r == 7) begin wb_valid = 1; wb_addr = 8; end
      tick();
    end
    idle();
    n_total++;
    if (pend1 !== 16'h00F0 || err1 !== 1'b1)
      $display("FAIL areset_pre: got p=%h err=%b required 00F0 / 1", pend1, err1);
    else n_pass++;
    #2;
    reset_n = 0;
    #1;
    n_total++;
    if ({pend1, we1, cnt1, err1, we3, pend3} !== '0)
      $display("FAIL areset_now: got p=%h we=%h cnt=%0d err=%b we3=%h required all 0",
               pend1, we1, cnt1, err1, we3);
    else n_pass++;
    model_clear();
    @(negedge clk);
    reset_n = 1;
    tick();
    n_total++;
    if (we3 !== 16'h0) $display("FAIL areset_flush: got we3=%h required 0", we3);
    else n_pass++;
  endtask

  task automatic test_random();
    int idx;
    for (int c = 0; c < 400; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 4'($urandom_range(0, 15));
      rd_en_a     = 1'($urandom_range(0, 1));
      rd_addr_a   = 4'($urandom_range(0, 15));
      rd_en_b     = 1'($urandom_range(0, 1));
      rd_addr_b   = 4'($urandom_range(0, 15));
      wb_valid    = ($urandom_range(0, 9) < 4);
      if (m_pend != 0 && $urandom_range(0, 9) != 0) begin
        do idx = $urandom_range(0, 15); while (!m_pend[idx]);
        wb_addr = 4'(idx);
      end else begin
        wb_addr = 4'($urandom_range(0, 15));
      end
      #1;
      n_total++;
      if (stall1 !== m_stall() || acc1 !== (issue_valid && !m_stall()) ||
          stall3 !== stall1 || acc3 !== acc1)
        $display("FAIL rand_stall[%0d]: got stall=%b acc=%b required %b / %b",
                 c, stall1, acc1, m_stall(), issue_valid && !m_stall());
      else n_pass++;
      tick();
      n_total++;
      if (pend1 !== m_pend || cnt1 !== m_count() || err1 !== m_err ||
          pend3 !== m_pend || cnt3 !== m_count() || err3 !== m_err)
        $display("FAIL rand_state[%0d]: got p=%h cnt=%0d err=%b required %h / %0d / %b",
                 c, pend1, cnt1, err1, m_pend, m_count(), m_err);
      else n_pass++;
      n_total++;
      if (we1 !== m_we(1) || we3 !== m_we(3))
        $display("FAIL rand_we[%0d]: got we1=%h we3=%h required %h / %h",
                 c, we1, we3, m_we(1), m_we(3));
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_decode();
    test_raw();
    test_waw();
    test_fill();
    test_wb_err();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
